// File: rtl/aes_cbc_dec_ctrl.sv
// aes_cbc_dec_ctrl: CBC chaining controller around an AES decipher core with a completion watchdog
module aes_cbc_dec_ctrl #(
  parameter int WATCHDOG_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         iv_load,
  input  logic [127:0] iv,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_block,
  output logic         core_next,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic [127:0] core_result,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_block,
  output logic         busy,
  output logic         error
);
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
  state_t state, state_nxt;
  logic [127:0] chain_reg, ct_reg, pt_reg;
  logic [WW-1:0] wd_ctr;
  logic error_reg;
  logic wd_exp;
  assign wd_exp = wd_ctr == WW'(WATCHDOG_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (s_valid && !iv_load) ? ISSUE : IDLE;
      ISSUE:   state_nxt = core_ready ? WAIT : ISSUE;
      WAIT:    state_nxt = core_ready ? OUT : (wd_exp ? IDLE : WAIT);
      default: state_nxt = m_ready ? IDLE : OUT;
    endcase
  end
  always_comb begin
    s_ready    = state == IDLE && !iv_load;
    core_next  = state == ISSUE && core_ready;
    m_valid    = state == OUT;
    busy       = state != IDLE;
    m_block    = pt_reg;
    core_block = ct_reg;
    error      = error_reg;
  end
  // ct_reg only loads in IDLE so the core sees a stable block through ISSUE and WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_reg <= '0;
      ct_reg    <= '0;
      pt_reg    <= '0;
      wd_ctr    <= '0;
      error_reg <= 1'b0;
    end else begin
      if (state == IDLE && iv_load) begin
        chain_reg <= iv;
        error_reg <= 1'b0;
      end
      if (state == IDLE && s_valid && !iv_load) ct_reg <= s_block;
      if (state == ISSUE && core_ready) wd_ctr <= '0;
      if (state == WAIT) begin
        if (core_ready) begin
          pt_reg    <= core_result ^ chain_reg;
          chain_reg <= ct_reg;
        end else begin
          wd_ctr <= wd_ctr + 1'b1;
          if (wd_exp) error_reg <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// tb_aes_cbc_dec_ctrl: directed checks of CBC chaining, backpressure, stalls, watchdog and reset
module tb_aes_cbc_dec_ctrl;
  localparam int WD  = 255;
  localparam int LAT = 12;
  localparam logic [127:0] IV1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] D1  = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] D2  = 128'hd86421fb9f1a1eda505ee1375746972c;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] K   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] C3  = 128'h11112222333344445555666677778888;
  localparam logic [127:0] C4  = 128'hdeadbeefcafef00d0123456789abcdef;
  localparam logic [127:0] C5  = 128'h0badc0de0badc0de0badc0de0badc0de;
  logic clk = 0, reset = 1, iv_load = 0, s_valid = 0, m_ready = 0;
  logic [127:0] iv = '0, s_block = '0;
  logic s_ready, core_next, core_ready, m_valid, busy, error;
  logic [127:0] core_block, core_result, m_block;
  logic rdy_m, hang = 0, hold_low = 0;
  int cnt;
  logic [127:0] res;
  int n_chk = 0, n_pass = 0;

  aes_cbc_dec_ctrl #(.WATCHDOG_CYCLES(WD)) dut (
    .clk(clk), .reset(reset), .iv_load(iv_load), .iv(iv),
    .s_valid(s_valid), .s_ready(s_ready), .s_block(s_block),
    .core_next(core_next), .core_block(core_block), .core_ready(core_ready),
    .core_result(core_result), .m_valid(m_valid), .m_ready(m_ready),
    .m_block(m_block), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] fake(input logic [127:0] x);
    return x == C1 ? D1 : x == C2 ? D2 : x ^ K;
  endfunction

  assign core_ready  = rdy_m & !hold_low;
  assign core_result = res;
  always @(posedge clk) begin
    if (reset) begin
      rdy_m <= 1'b1;
      cnt   <= 0;
      res   <= '0;
    end else if (core_next) begin
      rdy_m <= 1'b0;
      cnt   <= 0;
    end else if (!rdy_m) begin
      if (cnt == 0) res <= fake(core_block);
      cnt <= cnt + 1;
      if (cnt == LAT && !hang) rdy_m <= 1'b1;
    end
  end

  task automatic send(input logic [127:0] ct);
    int t = 0;
    while (!s_ready && t < 100) begin @(negedge clk); t++; end
    s_block = ct;
    s_valid = 1;
    @(negedge clk);
    s_valid = 0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!m_valid && cyc < 400) begin @(negedge clk); cyc++; end
    n_chk++;
    if (!m_valid) $display("FAIL wait_out: m_valid=0 after %0d cycles, required 1", cyc); else n_pass++;
  endtask

  task automatic accept();
    m_ready = 1;
    @(negedge clk);
    m_ready = 0;
    #1;
  endtask

  task automatic pulse_iv(input logic [127:0] v);
    iv = v;
    iv_load = 1;
    @(negedge clk);
    iv_load = 0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    n_chk++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready); else n_pass++;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
    n_chk++; if (m_block !== '0) $display("FAIL reset_m_block: got %h want 0", m_block); else n_pass++;
    n_chk++; if (core_next !== 1'b0 || core_block !== '0) $display("FAIL reset_core: next=%b block=%h want 0/0", core_next, core_block); else n_pass++;
  endtask

  task automatic test_nist();
    int cyc;
    @(negedge clk);
    iv = IV1; iv_load = 1; s_valid = 1; s_block = C1;
    #1;
    n_chk++; if (s_ready !== 1'b0) $display("FAIL ivload_s_ready: got %b want 0", s_ready); else n_pass++;
    @(negedge clk);
    iv_load = 0; s_valid = 0;
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL ivload_no_accept: busy=%b want 0", busy); else n_pass++;
    send(C1);
    wait_out(cyc);
    n_chk++; if (cyc != LAT + 4) $display("FAIL latency: got %0d want %0d", cyc, LAT + 4); else n_pass++;
    n_chk++; if (m_block !== P1) $display("FAIL nist_blk1: got %h want %h", m_block, P1); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL out_busy: got %b want 1", busy); else n_pass++;
    accept();
    n_chk++; if (m_valid !== 1'b0 || s_ready !== 1'b1) $display("FAIL nist_release: m_valid=%b s_ready=%b want 0/1", m_valid, s_ready); else n_pass++;
    send(C2);
    wait_out(cyc);
    n_chk++; if (m_block !== P2) $display("FAIL nist_blk2: got %h want %h", m_block, P2); else n_pass++;
    accept();
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [127:0] exp_pt = (C3 ^ K) ^ C2;
    logic stable = 1, no_next = 1, no_rdy = 1;
    send(C3);
    wait_out(cyc);
    n_chk++; if (m_block !== exp_pt) $display("FAIL bp_block: got %h want %h", m_block, exp_pt); else n_pass++;
    repeat (20) begin
      @(negedge clk);
      if (!m_valid || m_block !== exp_pt) stable = 0;
      if (core_next) no_next = 0;
      if (s_ready) no_rdy = 0;
    end
    n_chk++; if (!stable) $display("FAIL bp_stable: m_block/m_valid changed, want %h held", exp_pt); else n_pass++;
    n_chk++; if (!no_next) $display("FAIL bp_core_next: got 1 during hold want 0"); else n_pass++;
    n_chk++; if (!no_rdy) $display("FAIL bp_s_ready: got 1 during hold want 0"); else n_pass++;
    accept();
    n_chk++; if (m_valid !== 1'b0 || s_ready !== 1'b1) $display("FAIL bp_release: m_valid=%b s_ready=%b want 0/1", m_valid, s_ready); else n_pass++;
  endtask

  task automatic test_stall();
    int cyc;
    int t = 0;
    logic bad = 0, blk_bad = 0;
    hold_low = 1;
    send(C4);
    repeat (5) begin
      if (core_next !== 1'b0 || core_block !== C4 || !busy) bad = 1;
      @(negedge clk);
    end
    n_chk++; if (bad) $display("FAIL stall_issue: core_next asserted or core_block!=%h while core_ready=0", C4); else n_pass++;
    hold_low = 0;
    #1;
    n_chk++; if (core_next !== 1'b1) $display("FAIL stall_next_on: got %b want 1", core_next); else n_pass++;
    @(negedge clk);
    n_chk++; if (core_next !== 1'b0) $display("FAIL stall_next_off: got %b want 0", core_next); else n_pass++;
    while (!m_valid && t < 100) begin
      if (core_block !== C4) blk_bad = 1;
      @(negedge clk);
      t++;
    end
    n_chk++; if (blk_bad) $display("FAIL stall_core_block: changed in WAIT, want %h", C4); else n_pass++;
    wait_out(cyc);
    n_chk++; if (m_block !== ((C4 ^ K) ^ C3)) $display("FAIL stall_block: got %h want %h", m_block, (C4 ^ K) ^ C3); else n_pass++;
    accept();
  endtask

  task automatic test_watchdog();
    int cyc = 1;
    logic prev_err = 0, seen_mv = 0;
    hang = 1;
    send(C5);
    while (busy && cyc < 600) begin
      if (m_valid) seen_mv = 1;
      prev_err = error;
      @(negedge clk);
      cyc++;
    end
    n_chk++; if (cyc != WD + 2) $display("FAIL wd_time: idle after %0d cycles want %0d", cyc, WD + 2); else n_pass++;
    n_chk++; if (error !== 1'b1 || prev_err !== 1'b0) $display("FAIL wd_error: error=%b before=%b want 1/0", error, prev_err); else n_pass++;
    n_chk++; if (seen_mv || m_valid) $display("FAIL wd_m_valid: got 1 want 0"); else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++; if (error !== 1'b1) $display("FAIL wd_sticky: got %b want 1", error); else n_pass++;
    pulse_iv(IV1);
    n_chk++; if (error !== 1'b0) $display("FAIL wd_clear: got %b want 0", error); else n_pass++;
    hang = 0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    reset = 1;
    @(negedge clk);
    reset = 0;
    pulse_iv(IV1);
    send(C2);
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b1) $display("FAIL rmid_busy_before: got %b want 1", busy); else n_pass++;
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    n_chk++; if (busy !== 1'b0 || s_ready !== 1'b1 || core_next !== 1'b0) $display("FAIL rmid_state: busy=%b s_ready=%b core_next=%b want 0/1/0", busy, s_ready, core_next); else n_pass++;
    n_chk++; if (core_block !== '0 || m_block !== '0 || error !== 1'b0) $display("FAIL rmid_regs: core_block=%h m_block=%h error=%b want 0", core_block, m_block, error); else n_pass++;
    send(C1);
    wait_out(cyc);
    n_chk++; if (m_block !== D1) $display("FAIL rmid_chain_zero: got %h want %h", m_block, D1); else n_pass++;
  endtask

  task automatic test_iv_in_out();
    int cyc;
    pulse_iv({128{1'b1}});
    n_chk++; if (m_valid !== 1'b1 || m_block !== D1) $display("FAIL ivout_hold: m_valid=%b m_block=%h want 1/%h", m_valid, m_block, D1); else n_pass++;
    accept();
    send(C2);
    wait_out(cyc);
    n_chk++; if (m_block !== P2) $display("FAIL ivout_chain: got %h want %h", m_block, P2); else n_pass++;
    accept();
  endtask

  initial begin
    test_reset();
    test_nist();
    test_backpressure();
    test_stall();
    test_watchdog();
    test_reset_mid();
    test_iv_in_out();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
